// File: rtl/wb_ram_arbiter_b3.sv
// ============================================================================
//  Module   : wb_ram_arbiter_b3
//  Purpose  : Two-master Wishbone B3 round-robin arbiter with a per-grant
//             watchdog that aborts a stalled cycle with err.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_ram_arbiter_b3 #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int timeout_cycles = 255,
  parameter int tw             = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [aw-1:0] m0_adr_i,
  input  logic [1:0]    m0_bte_i,
  input  logic [2:0]    m0_cti_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [dw-1:0] m0_dat_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  input  logic [aw-1:0] m1_adr_i,
  input  logic [1:0]    m1_bte_i,
  input  logic [2:0]    m1_cti_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [dw-1:0] m1_dat_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic [aw-1:0] s_adr_o,
  output logic [1:0]    s_bte_o,
  output logic [2:0]    s_cti_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [dw-1:0] s_dat_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_GNT0 = 3'd1;
  localparam logic [2:0] c_GNT1 = 3'd2;
  localparam logic [2:0] c_ABT0 = 3'd3;
  localparam logic [2:0] c_ABT1 = 3'd4;

  localparam bit          c_WDOG_EN   = (timeout_cycles != 0);
  localparam logic [tw-1:0] c_WDOG_LAST = (timeout_cycles == 0) ? '0 : tw'(timeout_cycles - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic [tw-1:0] r_wdog;
  logic          r_abt_err;

  logic w_gnt0;
  logic w_gnt1;
  logic w_resp;
  logic w_stall_last;

  assign w_gnt0       = (r_state == c_GNT0);
  assign w_gnt1       = (r_state == c_GNT1);
  assign w_resp       = s_ack_i | s_err_i | s_rty_i;
  assign w_stall_last = c_WDOG_EN && (r_wdog == c_WDOG_LAST) && s_stb_o && !w_resp;

  // Grant only moves when the owner drops cyc, so bursts are never split.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      c_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
          w_state_nxt = c_GNT0;
          w_last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          w_state_nxt = c_GNT1;
          w_last_nxt  = 1'b1;
        end
      end
      c_GNT0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            w_state_nxt = c_GNT1;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = c_IDLE;
          end
        end else if (w_stall_last) begin
          w_state_nxt = c_ABT0;
        end
      end
      c_GNT1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            w_state_nxt = c_GNT0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = c_IDLE;
          end
        end else if (w_stall_last) begin
          w_state_nxt = c_ABT1;
        end
      end
      c_ABT0:  if (!m0_cyc_i) w_state_nxt = c_IDLE;
      c_ABT1:  if (!m1_cyc_i) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= c_IDLE;
      r_last    <= 1'b1;
      r_wdog    <= '0;
      r_abt_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_abt_err <= (w_gnt0 && w_state_nxt == c_ABT0) || (w_gnt1 && w_state_nxt == c_ABT1);
      if ((w_state_nxt != r_state) || w_resp || !s_stb_o)
        r_wdog <= '0;
      else if (w_gnt0 || w_gnt1)
        r_wdog <= r_wdog + 1'b1;
    end
  end

  assign s_adr_o = w_gnt1 ? m1_adr_i : m0_adr_i;
  assign s_bte_o = w_gnt1 ? m1_bte_i : m0_bte_i;
  assign s_cti_o = w_gnt1 ? m1_cti_i : m0_cti_i;
  assign s_sel_o = w_gnt1 ? m1_sel_i : m0_sel_i;
  assign s_dat_o = w_gnt1 ? m1_dat_i : m0_dat_i;
  assign s_cyc_o = (w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i);
  assign s_stb_o = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);
  assign s_we_o  = (w_gnt0 & m0_we_i)  | (w_gnt1 & m1_we_i);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = w_gnt0 & m0_cyc_i & s_ack_i;
  assign m0_rty_o = w_gnt0 & m0_cyc_i & s_rty_i;
  assign m0_err_o = (w_gnt0 & m0_cyc_i & s_err_i) | ((r_state == c_ABT0) & r_abt_err);
  assign m1_ack_o = w_gnt1 & m1_cyc_i & s_ack_i;
  assign m1_rty_o = w_gnt1 & m1_cyc_i & s_rty_i;
  assign m1_err_o = (w_gnt1 & m1_cyc_i & s_err_i) | ((r_state == c_ABT1) & r_abt_err);

endmodule

`default_nettype wire
